rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3: consecutive cycles an LU request may be refused before it is forced through.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-low.
REQ-004 pipe_we  input  1  pipeline writeback request; no backpressure.
REQ-005 pipe_rd  input  5  pipeline destination register.
REQ-006 pipe_data  input  32  pipeline writeback data.
REQ-007 lu_valid  input  1  long-latency unit (load/muldiv) write request.
REQ-008 lu_rd  input  5  LU destination register.
REQ-009 lu_data  input  32  LU writeback data.
REQ-010 lu_ready  output  1  LU request accepted this cycle.
REQ-011 iss_en  input  1  LU operation issued this cycle; marks iss_rd pending.
REQ-012 iss_rd  input  5  destination of the issued LU operation.
REQ-013 rs1  input  5  decode source 1 to check against the scoreboard.
REQ-014 rs2  input  5  decode source 2 to check against the scoreboard.
REQ-015 hazard  output  1  rs1 or rs2 awaits an LU writeback.
REQ-016 stall  output  1  freeze pipeline; hold buffer is draining.
REQ-017 rf_en  output  1  register file write enable.
REQ-018 rf_rd  output  5  register file write address.
REQ-019 rf_data  output  32  register file write data.

Function
REQ-020 Effective pipe request pipe_eff SHALL be pipe_we && pipe_rd!=0 && state==ARB_IDLE.
REQ-021 starve SHALL be (cnt==STARVE_MAX); cnt is a saturating counter of width clog2(STARVE_MAX+1).
REQ-022 In ARB_IDLE, lu_ready SHALL be combinational: !pipe_eff || starve; in ARB_HOLD, lu_ready SHALL be 0.
REQ-023 LU grant: a handshake completes when lu_valid && lu_ready; rf outputs carry lu_rd/lu_data, rf_en=(lu_rd!=0).
REQ-024 ARB_IDLE, pipe_eff, no LU grant: rf outputs carry pipe write, rf_en=1.
REQ-025 ARB_IDLE, pipe_eff and LU grant (starve case): pipe_rd/pipe_data captured in the hold buffer; next state ARB_HOLD.
REQ-026 ARB_HOLD: rf outputs carry the buffer contents, rf_en=1, stall=1, pipe_we ignored; next state ARB_IDLE.
REQ-027 stall SHALL be combinational (state==ARB_HOLD), so the freeze is asserted the cycle after the forced LU grant.
REQ-028 cnt SHALL clear on any LU grant, increment (saturating) when lu_valid && !lu_ready, and otherwise hold.
REQ-029 No request (or rd==0 only): rf_en=0, rf_rd and rf_data are don't-care and driven to 0.
REQ-030 Scoreboard: 32 pending bits; bit 0 is constant 0.
REQ-031 iss_en && iss_rd!=0 SHALL set pend[iss_rd] at the next edge.
REQ-032 An LU grant SHALL clear pend[lu_rd]; if the same register is set and cleared in one cycle, set wins.
REQ-033 hazard SHALL be pend[rs1] | pend[rs2], from registered bits only; the same-cycle iss_en is excluded and rs==0 never flags.
REQ-034 Write latency is 0 cycles (combinational to rf outputs); the worst-case pipe delay is 1 cycle via the hold buffer.

Reset
REQ-035 While rst==0 at an edge: state=ARB_IDLE, cnt=0, pend=0, buffer=0.
REQ-036 While rst==0: rf_en, lu_ready, stall and hazard SHALL be forced to 0.
REQ-037 A reset asserted in ARB_HOLD SHALL drop the buffered write; the write is not replayed.

Structure
REQ-038 rv_pkg SHALL hold XLEN=32, REG_ADDR_W=5, typedef wb_req_t {rd, data} and enum arb_state_t {ARB_IDLE, ARB_HOLD}.
REQ-039 The pending-bit logic SHALL be a sub-module rf_scoreboard (set/clear/query ports); arbitration and the FSM stay in the top level.

Verification
REQ-040 pipe_we=1 rd=5 data=0xA5 with lu_valid=0 -> same cycle rf_en=1, rf_rd=5, rf_data=0xA5, lu_ready=0.
REQ-041 pipe_we=1 every cycle, lu_valid=1 rd=7 data=0x11:
- cycles 0-2: lu_ready=0.
- cycle 3: lu_ready=1, rf writes x7=0x11, pipe write buffered.
- cycle 4: stall=1, buffered pipe write issued.
- cycle 5: stall=0, cnt=0.
REQ-042 iss_en=1 iss_rd=9, next cycle rs1=9 -> hazard=1; LU write to x9 granted -> hazard=0 the following cycle.
REQ-043 iss_en=1 iss_rd=4 in the same cycle as an LU grant for x4 -> pend[4] stays 1, hazard=1 with rs2=4.
REQ-044 Writes to register 0:
- pipe_we=1 rd=0: rf_en=0, no effect on the LU.
- lu_valid=1 rd=0: lu_ready=1, rf_en=0, scoreboard unchanged.
REQ-045 Assert rst=0 during ARB_HOLD -> next cycle stall=0, rf_en=0, pend all 0, state ARB_IDLE.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file writeback types: data/address widths, the writeback request
// and the arbiter state encoding.
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-writeback scoreboard: one bit per architectural register, set on LU issue
// and cleared on LU writeback.
module rf_scoreboard
  import rv_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_rd_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic                  hazard_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_rd_i] = 1'b0;
    // Set after clear so a same-cycle issue to the register being written back wins.
    if (set_en_i) pend_d[set_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  // Registered bits only; x0 can never be pending because bit 0 is held low.
  assign hazard_o = rst_ni & (pend_q[rs1_i] | pend_q[rs2_i]);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between the pipeline and a long-latency unit, with
// starvation-forced LU grants and a one-entry hold buffer for the displaced pipe write.
module rf_wb_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
  output logic                  lu_ready,
  input  logic                  iss_en,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  hazard,
  output logic                  stall,
  output logic                  rf_en,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_data
);

  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CntW-1:0] StarveCnt = CntW'(STARVE_MAX);

  arb_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  wb_req_t         buf_q, buf_d;
  logic            pipe_eff, starve, lu_grant;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    rf_en    = 1'b0;
    rf_rd    = '0;
    rf_data  = '0;
    lu_ready = 1'b0;
    stall    = 1'b0;
    pipe_eff = pipe_we && (pipe_rd != '0) && (state_q == ARB_IDLE);
    starve   = (cnt_q == StarveCnt);

    unique case (state_q)
      ARB_IDLE: begin
        lu_ready = !pipe_eff || starve;
        if (lu_valid && lu_ready) begin
          if (lu_rd != '0) begin
            rf_en   = 1'b1;
            rf_rd   = lu_rd;
            rf_data = lu_data;
          end
          // Forced LU grant displaces the pipe write into the hold buffer.
          if (pipe_eff) begin
            buf_d   = '{rd: pipe_rd, data: pipe_data};
            state_d = ARB_HOLD;
          end
        end else if (pipe_eff) begin
          rf_en   = 1'b1;
          rf_rd   = pipe_rd;
          rf_data = pipe_data;
        end
      end
      ARB_HOLD: begin
        stall   = 1'b1;
        rf_en   = 1'b1;
        rf_rd   = buf_q.rd;
        rf_data = buf_q.data;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    lu_grant = lu_valid && lu_ready;
    if (lu_grant)                             cnt_d = '0;
    else if (lu_valid && cnt_q != StarveCnt)  cnt_d = cnt_q + CntW'(1);

    if (!rst) begin
      rf_en    = 1'b0;
      rf_rd    = '0;
      rf_data  = '0;
      lu_ready = 1'b0;
      stall    = 1'b0;
      lu_grant = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  rf_scoreboard u_scoreboard (
    .clk_i    (clk),
    .rst_ni   (rst),
    .set_en_i (iss_en && (iss_rd != '0)),
    .set_rd_i (iss_rd),
    .clr_en_i (lu_grant),
    .clr_rd_i (lu_rd),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .hazard_o (hazard)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and randomized bench for rf_wb_arbiter against a cycle-level reference model.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;

  localparam int STARVE = 3;

  logic        clk = 1'b0;
  logic        rst, pipe_we, lu_valid, iss_en;
  logic [4:0]  pipe_rd, lu_rd, iss_rd, rs1, rs2;
  logic [31:0] pipe_data, lu_data;
  logic        lu_ready, hazard, stall, rf_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_hold;
  logic [4:0]  m_hrd;
  logic [31:0] m_hdata;
  int          m_cnt;
  bit          m_pend [32];
  bit          m_grant, m_peff, m_ready;

  always #50 clk = ~clk;

  rf_wb_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_rd   (pipe_rd),
    .pipe_data (pipe_data),
    .lu_valid  (lu_valid),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .lu_ready  (lu_ready),
    .iss_en    (iss_en),
    .iss_rd    (iss_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .hazard    (hazard),
    .stall     (stall),
    .rf_en     (rf_en),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Settle combinational outputs mid-cycle and compare them with the model.
  task automatic observe();
    bit          e_en, e_haz;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    #1;
    if (!rst) begin
      chk("rst_rf_en", rf_en, 0);
      chk("rst_lu_ready", lu_ready, 0);
      chk("rst_stall", stall, 0);
      chk("rst_hazard", hazard, 0);
      m_grant = 0;
      m_peff  = 0;
      return;
    end
    m_peff  = pipe_we && pipe_rd != 0 && !m_hold;
    m_ready = !m_hold && (!m_peff || m_cnt == STARVE);
    m_grant = lu_valid && m_ready;
    e_haz   = m_pend[rs1] || m_pend[rs2];
    if (m_hold) begin
      e_en = 1; e_rd = m_hrd; e_data = m_hdata;
    end else if (m_grant) begin
      e_en = (lu_rd != 0); e_rd = e_en ? lu_rd : 5'd0; e_data = e_en ? lu_data : 32'd0;
    end else if (m_peff) begin
      e_en = 1; e_rd = pipe_rd; e_data = pipe_data;
    end else begin
      e_en = 0; e_rd = 0; e_data = 0;
    end
    chk("m_rf_en", rf_en, e_en);
    chk("m_rf_rd", rf_rd, e_rd);
    chk("m_rf_data", rf_data, e_data);
    chk("m_lu_ready", lu_ready, m_ready);
    chk("m_stall", stall, m_hold);
    chk("m_hazard", hazard, e_haz);
  endtask

  // Clock edge, then advance the model with the inputs that were applied.
  task automatic advance();
    @(posedge clk);
    if (!rst) begin
      m_hold = 0; m_cnt = 0; m_hrd = 0; m_hdata = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      if (m_grant && m_peff) begin
        m_hold = 1; m_hrd = pipe_rd; m_hdata = pipe_data;
      end else begin
        m_hold = 0;
      end
      if (m_grant)                    m_cnt = 0;
      else if (lu_valid && !m_ready)  m_cnt = (m_cnt + 1 > STARVE) ? STARVE : m_cnt + 1;
      if (m_grant)                    m_pend[lu_rd] = 0;
      if (iss_en && iss_rd != 0)      m_pend[iss_rd] = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    iss_en = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    @(negedge clk);

    // Reset: everything quiescent even with requests present
    pipe_we = 1; pipe_rd = 5'd2; lu_valid = 1; lu_rd = 5'd3;
    observe(); advance();
    idle_inputs();
    observe(); advance();
    rst = 1;

    // Plain pipe write, no LU traffic
    pipe_we = 1; pipe_rd = 5'd5; pipe_data = 32'hA5;
    observe();
    chk("pipe_rf_en", rf_en, 1);
    chk("pipe_rf_rd", rf_rd, 5);
    chk("pipe_rf_data", rf_data, 32'hA5);
    chk("pipe_lu_ready", lu_ready, 0);
    advance();

    // Starvation: LU refused three cycles then forced through
    pipe_we = 1; pipe_rd = 5'd3; pipe_data = 32'h33;
    lu_valid = 1; lu_rd = 5'd7; lu_data = 32'h11;
    for (int c = 0; c < 3; c++) begin
      observe();
      chk("starve_refuse", lu_ready, 0);
      advance();
    end
    observe();
    chk("starve_grant_ready", lu_ready, 1);
    chk("starve_grant_rd", rf_rd, 7);
    chk("starve_grant_data", rf_data, 32'h11);
    advance();
    lu_valid = 0; pipe_rd = 5'd12; pipe_data = 32'hDEAD;
    observe();
    chk("hold_stall", stall, 1);
    chk("hold_rd", rf_rd, 3);
    chk("hold_data", rf_data, 32'h33);
    advance();
    observe();
    chk("post_hold_stall", stall, 0);
    chk("post_hold_pipe_rd", rf_rd, 12);
    lu_valid = 1;
    #1 chk("post_hold_cnt_clear", lu_ready, 0);
    advance();

    // LU write to x0 with no pipe traffic: accepted, nothing written
    pipe_we = 0; lu_valid = 1; lu_rd = 5'd0; lu_data = 32'hFFFF;
    observe();
    chk("lu_x0_ready", lu_ready, 1);
    chk("lu_x0_rf_en", rf_en, 0);
    advance();

    // Scoreboard set / query / clear
    lu_valid = 0; iss_en = 1; iss_rd = 5'd9; rs1 = 5'd9;
    observe();
    chk("sb_same_cycle", hazard, 0);
    advance();
    iss_en = 0;
    observe();
    chk("sb_set", hazard, 1);
    lu_valid = 1; lu_rd = 5'd9; lu_data = 32'h99;
    observe();
    advance();
    lu_valid = 0;
    observe();
    chk("sb_cleared", hazard, 0);
    advance();

    // Same-cycle set and clear of x4: set wins
    iss_en = 1; iss_rd = 5'd4;
    observe(); advance();
    lu_valid = 1; lu_rd = 5'd4; lu_data = 32'h44;
    observe(); advance();
    iss_en = 0; lu_valid = 0; rs1 = 5'd0; rs2 = 5'd4;
    observe();
    chk("sb_set_wins", hazard, 1);
    advance();

    // Pipe write to x0: nothing written, LU unaffected
    pipe_we = 1; pipe_rd = 5'd0; pipe_data = 32'h77;
    observe();
    chk("pipe_x0_rf_en", rf_en, 0);
    chk("pipe_x0_rf_data", rf_data, 0);
    lu_valid = 1; lu_rd = 5'd6; lu_data = 32'h66;
    observe();
    chk("pipe_x0_lu_ready", lu_ready, 1);
    advance();

    // Reset during hold: buffered write dropped, scoreboard cleared
    pipe_we = 1; pipe_rd = 5'd8; pipe_data = 32'h88;
    lu_valid = 1; lu_rd = 5'd10; lu_data = 32'hAA;
    iss_en = 1; iss_rd = 5'd20;
    for (int c = 0; c < 4; c++) begin
      observe(); advance();
    end
    iss_en = 0; lu_valid = 0;
    #1 chk("rh_in_hold", stall, 1);
    rst = 0;
    observe();
    advance();
    rst = 1; pipe_we = 0;
    observe();
    chk("rh_stall", stall, 0);
    chk("rh_rf_en", rf_en, 0);
    for (int r = 1; r < 32; r++) begin
      rs1 = 5'(r); rs2 = 5'(r);
      #1 chk("rh_pend_clear", hazard, 0);
    end
    advance();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 59) != 0);
      pipe_we   = ($urandom_range(0, 3) != 0);
      pipe_rd   = 5'($urandom_range(0, 31));
      pipe_data = $urandom;
      lu_valid  = ($urandom_range(0, 2) != 0);
      lu_rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      lu_data   = $urandom;
      iss_en    = ($urandom_range(0, 1) != 0);
      iss_rd    = 5'($urandom_range(0, 7));
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      observe();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
